motion_stepgen_mc: RTL and testbench

MOTION_STEPGEN_MC -- requirements
Module: motion_stepgen_mc

---
 rtl/motion_stepgen_mc.sv | 210 +++++++++++++++++++++
 tb/tb_motion_stepgen_mc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_stepgen_mc.sv
// Multi-axis step/direction pulse generator with a small register bus.
// Each axis runs an IDLE/WAIT/PULSE sequencer gated by synchronised endstop/probe inputs.
module motion_stepgen_mc #(
  parameter int NUM_AXES = 4,
  parameter int CNT_W    = 32,
  parameter int PULSE_W  = 4
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                Reg_Wr,
  input  logic                Reg_Rd,
  input  logic [4:0]          Reg_Addr,
  input  logic [31:0]         Reg_WData,
  output logic [31:0]         Reg_RData,
  output logic                Reg_Ack,
  output logic [NUM_AXES-1:0] S_Step,
  output logic [NUM_AXES-1:0] S_Dir,
  output logic [NUM_AXES-1:0] S_Enable,
  input  logic [NUM_AXES-1:0] E_Min,
  input  logic [NUM_AXES-1:0] E_Max,
  input  logic                E_Probe,
  output logic [NUM_AXES-1:0] IntrEvent
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_PULSE = 2'd2} state_t;

  logic [2:0] axis_sel;
  logic [1:0] reg_sel;
  assign axis_sel = Reg_Addr[4:2];
  assign reg_sel  = Reg_Addr[1:0];

  // The pulse must fit inside one period, so short periods are stretched.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
    if (p < CNT_W'(PULSE_W + 1)) return CNT_W'(PULSE_W + 1);
    return p;
  endfunction

  logic [NUM_AXES-1:0] emin_s1, emin_s2, emax_s1, emax_s2;
  logic                probe_s1, probe_s2;

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      emin_s1  <= '0;
      emin_s2  <= '0;
      emax_s1  <= '0;
      emax_s2  <= '0;
      probe_s1 <= 1'b0;
      probe_s2 <= 1'b0;
    end else begin
      emin_s1  <= E_Min;
      emin_s2  <= emin_s1;
      emax_s1  <= E_Max;
      emax_s2  <= emax_s1;
      probe_s1 <= E_Probe;
      probe_s2 <= probe_s1;
    end
  end

  logic [NUM_AXES-1:0][3:0][31:0] rd_word;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic             hit, ctrl_wr, period_wr, steps_wr, status_rd;
    logic [CNT_W-1:0] period_r, steps_r, period_run, remaining, cnt;
    logic             dir_r, en_r, probe_en_r, dir_run, busy, err, abort_pend;
    logic             step_q, intr_q;
    logic [1:0]       cause;
    logic [3:0]       pcnt;
    state_t           state;
    logic             end_hit, probe_hit, stop_now;
    logic [1:0]       stop_cause;

    assign hit       = (axis_sel == 3'(i));
    assign ctrl_wr   = Reg_Wr && hit && (reg_sel == 2'd0);
    assign period_wr = Reg_Wr && hit && (reg_sel == 2'd1);
    assign steps_wr  = Reg_Wr && hit && (reg_sel == 2'd2);
    assign status_rd = Reg_Rd && hit && (reg_sel == 2'd3);

    always_comb begin
      end_hit    = dir_run ? emax_s2[i] : emin_s2[i];
      probe_hit  = probe_en_r && probe_s2;
      stop_now   = abort_pend || end_hit || probe_hit;
      stop_cause = 2'd0;
      if (abort_pend)     stop_cause = 2'd3;
      else if (end_hit)   stop_cause = 2'd1;
      else if (probe_hit) stop_cause = 2'd2;
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
        period_r   <= '0;
        steps_r    <= '0;
        period_run <= '0;
        remaining  <= '0;
        cnt        <= '0;
        dir_r      <= 1'b0;
        en_r       <= 1'b0;
        probe_en_r <= 1'b0;
        dir_run    <= 1'b0;
        busy       <= 1'b0;
        err        <= 1'b0;
        abort_pend <= 1'b0;
        step_q     <= 1'b0;
        intr_q     <= 1'b0;
        cause      <= 2'd0;
        pcnt       <= '0;
        state      <= ST_IDLE;
      end else begin
        intr_q <= 1'b0;
        if (ctrl_wr) begin
          dir_r      <= Reg_WData[1];
          en_r       <= Reg_WData[2];
          probe_en_r <= Reg_WData[3];
        end
        if (period_wr) period_r <= Reg_WData[CNT_W-1:0];
        if (steps_wr)  steps_r  <= Reg_WData[CNT_W-1:0];
        if (status_rd) err <= 1'b0;
        if (ctrl_wr && busy) begin
          if (Reg_WData[0]) err        <= 1'b1;
          if (Reg_WData[4]) abort_pend <= 1'b1;
        end

        case (state)
          ST_IDLE: begin
            abort_pend <= 1'b0;
            if (ctrl_wr && Reg_WData[0]) begin
              cause <= 2'd0;
              if (steps_r == '0) begin
                intr_q    <= 1'b1;
                remaining <= '0;
              end else begin
                dir_run    <= Reg_WData[1];
                period_run <= eff_period(period_r);
                cnt        <= eff_period(period_r);
                remaining  <= steps_r;
                busy       <= 1'b1;
                state      <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (stop_now) begin
              cause      <= stop_cause;
              busy       <= 1'b0;
              intr_q     <= 1'b1;
              abort_pend <= 1'b0;
              state      <= ST_IDLE;
            end else if (cnt == CNT_W'(1)) begin
              // Reload here so rising-edge spacing does not depend on PULSE_W.
              cnt       <= period_run;
              step_q    <= 1'b1;
              pcnt      <= 4'(PULSE_W - 1);
              remaining <= remaining - CNT_W'(1);
              state     <= ST_PULSE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_PULSE: begin
            cnt <= cnt - CNT_W'(1);
            if (pcnt == 4'd0) begin
              step_q <= 1'b0;
              if (remaining == '0 || stop_now) begin
                cause      <= (remaining == '0) ? 2'd0 : stop_cause;
                busy       <= 1'b0;
                intr_q     <= 1'b1;
                abort_pend <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              pcnt <= pcnt - 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign S_Step[i]    = step_q;
    assign S_Dir[i]     = dir_run;
    assign S_Enable[i]  = en_r;
    assign IntrEvent[i] = intr_q;

    assign rd_word[i][0] = {28'd0, probe_en_r, en_r, dir_r, 1'b0};
    assign rd_word[i][1] = 32'(period_r);
    assign rd_word[i][2] = 32'(steps_r);
    assign rd_word[i][3] = {24'(remaining), 4'd0, err, cause, busy};
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    for (int a = 0; a < NUM_AXES; a++) begin
      if (axis_sel == 3'(a)) rd_mux = rd_word[a][reg_sel];
    end
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      Reg_Ack   <= 1'b0;
      Reg_RData <= 32'd0;
    end else begin
      Reg_Ack   <= Reg_Wr || Reg_Rd;
      Reg_RData <= Reg_Rd ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_motion_stepgen_mc.sv
// Directed bench for motion_stepgen_mc: register table plus hand-built motion sequences.
module tb_motion_stepgen_mc;
  localparam int NA = 4;
  localparam int PW = 4;

  logic          clk, rst;
  logic          Reg_Wr, Reg_Rd;
  logic [4:0]    Reg_Addr;
  logic [31:0]   Reg_WData, Reg_RData;
  logic          Reg_Ack;
  logic [NA-1:0] S_Step, S_Dir, S_Enable, E_Min, E_Max, IntrEvent;
  logic          E_Probe;

  motion_stepgen_mc #(.NUM_AXES(NA), .CNT_W(32), .PULSE_W(PW)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Reset(rst), .Reg_Wr(Reg_Wr), .Reg_Rd(Reg_Rd),
    .Reg_Addr(Reg_Addr), .Reg_WData(Reg_WData), .Reg_RData(Reg_RData), .Reg_Ack(Reg_Ack),
    .S_Step(S_Step), .S_Dir(S_Dir), .S_Enable(S_Enable), .E_Min(E_Min), .E_Max(E_Max),
    .E_Probe(E_Probe), .IntrEvent(IntrEvent));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  int            rise_t [NA][128];
  int            width_t[NA][128];
  int            npulse [NA];
  int            nintr  [NA];
  int            last_intr[NA];
  logic [NA-1:0] prev_step = '0;

  always @(negedge clk) begin
    for (int a = 0; a < NA; a++) begin
      if (S_Step[a] && !prev_step[a]) begin
        if (npulse[a] < 128) rise_t[a][npulse[a]] = cyc;
        npulse[a]++;
      end
      if (!S_Step[a] && prev_step[a] && npulse[a] > 0 && npulse[a] <= 128)
        width_t[a][npulse[a]-1] = cyc - rise_t[a][npulse[a]-1];
      if (IntrEvent[a]) begin
        nintr[a]++;
        last_intr[a] = cyc;
      end
    end
    prev_step = S_Step;
  end

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int a = 0; a < NA; a++) begin
      npulse[a]    = 0;
      nintr[a]     = 0;
      last_intr[a] = 0;
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    Reg_Addr  = a;
    Reg_WData = d;
    Reg_Wr    = 1'b1;
    @(posedge clk);
    #1;
    Reg_Wr = 1'b0;
    chk("wr_ack", Reg_Ack, 1'b1);
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    Reg_Addr = a;
    Reg_Rd   = 1'b1;
    @(posedge clk);
    #1;
    Reg_Rd = 1'b0;
    d = Reg_RData;
    chk("rd_ack", Reg_Ack, 1'b1);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic wait_pulses(input int a, input int n, input int budget);
    int k = 0;
    while (npulse[a] < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("wait_pulses_ax%0d", a), 32'(npulse[a] >= n), 32'd1);
  endtask

  task automatic wait_intr(input int a, input int budget);
    int k = 0;
    while (nintr[a] == 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("wait_intr_ax%0d", a), 32'(nintr[a] > 0), 32'd1);
  endtask

  task automatic check_train(input string nm, input int a, input int n, input int sp, input int start);
    int bad_sp = 0;
    int bad_w  = 0;
    chk({nm, "_count"}, 32'(npulse[a]), 32'(n));
    if (npulse[a] > 0) chk({nm, "_first"}, 32'(rise_t[a][0] - start), 32'(sp));
    for (int k = 1; k < npulse[a] && k < 128; k++)
      if (rise_t[a][k] - rise_t[a][k-1] != sp) bad_sp++;
    for (int k = 0; k < npulse[a] && k < 128; k++)
      if (width_t[a][k] != PW) bad_w++;
    chk({nm, "_spacing_errs"}, 32'(bad_sp), 32'd0);
    chk({nm, "_width_errs"}, 32'(bad_w), 32'd0);
  endtask

  initial begin
    int start_cyc;
    int intr_before;
    rst = 1'b1; Reg_Wr = 1'b0; Reg_Rd = 1'b0; Reg_Addr = '0; Reg_WData = '0;
    E_Min = '0; E_Max = '0; E_Probe = 1'b0;
    clear_mon();
    #1;
    chk("rst_step", {28'd0, S_Step}, 32'd0);
    chk("rst_outs", {S_Dir, S_Enable, IntrEvent}, 12'd0);
    chk("rst_ack", {31'd0, Reg_Ack}, 32'd0);
    chk("rst_rdata", Reg_RData, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // register table: axis index in Reg_Addr[4:2], register in [1:0]
    vt[0]  = '{1'b1, 5'd1,  32'd20,        32'd0};
    vt[1]  = '{1'b1, 5'd2,  32'd10,        32'd0};
    vt[2]  = '{1'b0, 5'd1,  32'd0,         32'd20};
    vt[3]  = '{1'b0, 5'd2,  32'd0,         32'd10};
    vt[4]  = '{1'b1, 5'd5,  32'hFFFF1234,  32'd0};
    vt[5]  = '{1'b0, 5'd5,  32'd0,         32'hFFFF1234};
    vt[6]  = '{1'b1, 5'd21, 32'd77,        32'd0};
    vt[7]  = '{1'b0, 5'd21, 32'd0,         32'd0};
    vt[8]  = '{1'b1, 5'd8,  32'h000000F4,  32'd0};
    vt[9]  = '{1'b0, 5'd8,  32'd0,         32'd4};
    vt[10] = '{1'b1, 5'd3,  32'hFFFFFFFF,  32'd0};
    vt[11] = '{1'b0, 5'd3,  32'd0,         32'd0};
    for (int v = 0; v < 12; v++) begin
      if (vt[v].wr) bus_wr(vt[v].addr, vt[v].data);
      else rd_chk($sformatf("table_rd_%0d", v), vt[v].addr, vt[v].exp);
    end
    chk("enable_ax2", {28'd0, S_Enable}, 32'h4);
    chk("no_pulse_idle", {28'd0, S_Step}, 32'd0);

    // axis0: 10 pulses, 20 clocks apart
    clear_mon();
    bus_wr(5'd0, 32'h7);
    start_cyc = cyc;
    chk("ax0_dir", {31'd0, S_Dir[0]}, 32'd1);
    while (cyc < start_cyc + 50) begin @(posedge clk); #1; end
    rd_chk("ax0_status_mid", 5'd3, 32'h0000_0801);
    wait_intr(0, 400);
    repeat (5) @(posedge clk);
    #1;
    check_train("ax0", 0, 10, 20, start_cyc);
    chk("ax0_intr_cnt", 32'(nintr[0]), 32'd1);
    chk("ax0_intr_time", 32'(last_intr[0] - start_cyc), 32'(200 + PW));
    rd_chk("ax0_status_end", 5'd3, 32'd0);

    // axis3: PERIOD=2 is stretched to PULSE_W+1
    clear_mon();
    bus_wr(5'd13, 32'd2);
    bus_wr(5'd14, 32'd3);
    bus_wr(5'd12, 32'h1);
    start_cyc = cyc;
    wait_intr(3, 100);
    repeat (3) @(posedge clk);
    #1;
    check_train("ax3_short", 3, 3, PW + 1, start_cyc);
    chk("ax3_intr_time", 32'(last_intr[3] - start_cyc), 32'(3 * (PW + 1) + PW));

    // axis1: dir=0, E_Max ignored, E_Min stops the move after pulse 3
    clear_mon();
    E_Max[1] = 1'b1;
    bus_wr(5'd5, 32'd10);
    bus_wr(5'd6, 32'd100);
    bus_wr(5'd4, 32'h1);
    wait_pulses(1, 3, 100);
    E_Min[1] = 1'b1;
    wait_intr(1, 100);
    repeat (30) @(posedge clk);
    #1;
    chk("ax1_pulses", 32'(npulse[1]), 32'd3);
    chk("ax1_intr_cnt", 32'(nintr[1]), 32'd1);
    rd_chk("ax1_status", 5'd7, 32'h0000_6102);
    E_Min[1] = 1'b0;
    E_Max[1] = 1'b0;

    // axis2: start while busy sets err; STEPS write does not touch the run
    clear_mon();
    bus_wr(5'd9, 32'd8);
    bus_wr(5'd10, 32'd5);
    bus_wr(5'd8, 32'h1);
    start_cyc = cyc;
    repeat (12) @(posedge clk);
    #1;
    bus_wr(5'd8, 32'h1);
    bus_wr(5'd10, 32'd50);
    wait_intr(2, 200);
    repeat (3) @(posedge clk);
    #1;
    check_train("ax2", 2, 5, 8, start_cyc);
    chk("ax2_intr_cnt", 32'(nintr[2]), 32'd1);
    rd_chk("ax2_status_err", 5'd11, 32'h8);
    rd_chk("ax2_status_clr", 5'd11, 32'h0);
    rd_chk("ax2_steps_reg", 5'd10, 32'd50);

    // axis3: abort and E_Max together -> abort wins
    clear_mon();
    bus_wr(5'd13, 32'd10);
    bus_wr(5'd14, 32'd20);
    bus_wr(5'd12, 32'h3);
    wait_pulses(3, 2, 100);
    E_Max[3] = 1'b1;
    bus_wr(5'd12, 32'h12);
    wait_intr(3, 100);
    repeat (20) @(posedge clk);
    #1;
    chk("ax3_abort_pulses", 32'(npulse[3]), 32'd2);
    chk("ax3_abort_intr", 32'(nintr[3]), 32'd1);
    rd_chk("ax3_abort_status", 5'd15, 32'h0000_1206);
    E_Max[3] = 1'b0;

    // axis0: probe stop
    clear_mon();
    bus_wr(5'd1, 32'd10);
    bus_wr(5'd2, 32'd20);
    bus_wr(5'd0, 32'h9);
    wait_pulses(0, 1, 100);
    E_Probe = 1'b1;
    wait_intr(0, 100);
    repeat (20) @(posedge clk);
    #1;
    chk("ax0_probe_pulses", 32'(npulse[0]), 32'd1);
    rd_chk("ax0_probe_status", 5'd3, 32'h0000_1304);
    E_Probe = 1'b0;

    // axis1: start with STEPS=0 completes immediately
    clear_mon();
    bus_wr(5'd6, 32'd0);
    bus_wr(5'd4, 32'h1);
    chk("zero_intr_now", {31'd0, IntrEvent[1]}, 32'd1);
    @(posedge clk);
    #1;
    chk("zero_intr_once", {31'd0, IntrEvent[1]}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("zero_pulses", 32'(npulse[1]), 32'd0);
    rd_chk("zero_status", 5'd7, 32'd0);

    // reset in the middle of a pulse
    clear_mon();
    bus_wr(5'd1, 32'd20);
    bus_wr(5'd2, 32'd10);
    bus_wr(5'd0, 32'h5);
    wait_pulses(0, 1, 100);
    intr_before = nintr[0];
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_step", {31'd0, S_Step[0]}, 32'd0);
    chk("rst_mid_en", {31'd0, S_Enable[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mid_no_intr", 32'(nintr[0]), 32'(intr_before));
    chk("rst_mid_no_more_pulses", 32'(npulse[0]), 32'd1);
    rd_chk("rst_mid_status", 5'd3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
